// File: rtl/cas_fsk_stream.sv
`default_nettype none
// ============================================================================
// Module      : cas_fsk_stream
// Description : Cassette FSK bit-stream encoder. Buffers one word behind a
//               valid/ready handshake and serialises it as square-wave
//               cycles (short cycle = '1', long cycle = '0'), timed by a
//               fractional phase accumulator. Words run back-to-back with
//               continuous phase when a follow-on word is already held.
// Revision    : 1.0 - initial release
// ============================================================================
module cas_fsk_stream #(
    parameter int   ACC_W     = 24,
    parameter int   STP       = 703,
    parameter int   DW        = 8,
    parameter int   H1        = 1,
    parameter int   H0        = 2,
    parameter logic IDLE_LVL  = 1'b1,
    parameter int   LSB_FIRST = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic          dout,
    output logic          busy,
    output logic          word_done
);

    localparam int c_HMAX  = (H0 > H1) ? H0 : H1;
    localparam int c_CNT_W = $clog2(2 * c_HMAX);
    localparam int c_IDX_W = (DW > 1) ? $clog2(DW) : 1;

    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DW - 1);
    localparam logic [ACC_W:0]     c_STP      = (ACC_W + 1)'(STP);
    localparam logic [c_CNT_W:0]   c_H1       = (c_CNT_W + 1)'(H1);
    localparam logic [c_CNT_W:0]   c_H0       = (c_CNT_W + 1)'(H0);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    // Bit currently presented at the send end of a shifter image
    function automatic logic f_send_bit(input logic [DW-1:0] s);
        return (LSB_FIRST != 0) ? s[0] : s[DW-1];
    endfunction

    logic [0:0]         r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_IDX_W-1:0] r_idx;
    logic [DW-1:0]      r_shift;
    logic [DW-1:0]      r_hold;
    logic               r_hold_valid;
    logic               r_dout;
    logic               r_busy;
    logic               r_word_done;

    logic [ACC_W:0]     w_sum;
    logic               w_tick;
    logic [c_CNT_W:0]   w_half;
    logic [c_CNT_W:0]   w_cyc_last;
    logic               w_bit_end;
    logic               w_word_end;
    logic               w_accept;
    logic               w_load;
    logic [0:0]         w_state_nxt;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [c_IDX_W-1:0] w_idx_nxt;
    logic [DW-1:0]      w_shift_nxt;
    logic [c_CNT_W:0]   w_nhalf;
    logic               w_dout_nxt;

    assign din_ready = ~reset & ~r_hold_valid;
    assign dout      = r_dout;
    assign busy      = r_busy;
    assign word_done = r_word_done;

    // Next-state decode: tick generation, bit/word boundaries, shifter reloads
    always_comb begin
        w_sum       = {1'b0, r_acc} + c_STP;
        w_tick      = w_sum[ACC_W];
        w_half      = f_send_bit(r_shift) ? c_H1 : c_H0;
        w_cyc_last  = {w_half[c_CNT_W-1:0], 1'b0} - 1'b1;
        w_bit_end   = (r_state == S_RUN) && w_tick && ({1'b0, r_cnt} == w_cyc_last);
        w_word_end  = w_bit_end && (r_idx == c_IDX_LAST);
        w_accept    = din_valid && din_ready;

        w_load      = 1'b0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;

        if (r_state == S_IDLE) begin
            if (r_hold_valid) begin
                w_load      = 1'b1;
                w_state_nxt = S_RUN;
                w_shift_nxt = r_hold;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        end else begin
            if (w_word_end) begin
                w_cnt_nxt = '0;
                w_idx_nxt = '0;
                if (r_hold_valid) begin
                    w_load      = 1'b1;
                    w_shift_nxt = r_hold;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end else if (w_bit_end) begin
                w_cnt_nxt   = '0;
                w_idx_nxt   = r_idx + 1'b1;
                w_shift_nxt = (LSB_FIRST != 0) ? (r_shift >> 1) : (r_shift << 1);
            end else if (w_tick) begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end

        // Phase only advances while running continuously; any entry to or
        // exit from IDLE leaves the accumulator at zero.
        w_acc_nxt = ((r_state == S_RUN) && (w_state_nxt == S_RUN)) ? w_sum[ACC_W-1:0] : '0;

        // Output level follows the half-cycle position the next state will hold
        w_nhalf    = f_send_bit(w_shift_nxt) ? c_H1 : c_H0;
        w_dout_nxt = ((w_state_nxt == S_RUN) && ({1'b0, w_cnt_nxt} >= w_nhalf)) ? ~IDLE_LVL : IDLE_LVL;
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shift      <= '0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_dout       <= IDLE_LVL;
            r_busy       <= 1'b0;
            r_word_done  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_dout      <= w_dout_nxt;
            r_busy      <= (w_state_nxt == S_RUN);
            r_word_done <= w_word_end;
            if (w_accept) begin
                r_hold       <= din;
                r_hold_valid <= 1'b1;
            end else if (w_load) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cas_fsk_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_cas_fsk_stream
// Description : Self-checking bench for cas_fsk_stream. Two instances (LSB
//               first and MSB first) share one stimulus stream; a tick-level
//               waveform model predicts every output on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cas_fsk_stream;

    localparam int ACC_W = 4;
    localparam int STP   = 8;
    localparam int DW    = 8;
    localparam int H1    = 1;
    localparam int H0    = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] din = '0;
    logic          din_valid = 1'b0;
    logic [1:0]    rdy;
    logic [1:0]    dout;
    logic [1:0]    busy;
    logic [1:0]    wd;

    always #5 clk = ~clk;

    cas_fsk_stream #(.ACC_W(ACC_W), .STP(STP), .DW(DW), .H1(H1), .H0(H0),
                     .IDLE_LVL(1'b1), .LSB_FIRST(1)) u_dut_lsb (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(rdy[0]), .dout(dout[0]), .busy(busy[0]), .word_done(wd[0]));

    cas_fsk_stream #(.ACC_W(ACC_W), .STP(STP), .DW(DW), .H1(H1), .H0(H0),
                     .IDLE_LVL(1'b1), .LSB_FIRST(0)) u_dut_msb (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(rdy[1]), .dout(dout[1]), .busy(busy[1]), .word_done(wd[1]));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h required %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model: per-tick waveform playback ----------
    bit         m_on = 1'b0;
    bit         m_run [2];
    bit         m_hv  [2];
    int         m_acc [2];
    int         m_pos [2];
    int         m_len [2];
    logic [7:0] m_hold[2];
    logic       m_wave[2][64];
    logic       e_dout[2];
    logic       e_busy[2];
    logic       e_wd  [2];

    // Expand a word into one output level per tick
    task automatic load_word(input int k, input logic [7:0] w);
        m_len[k] = 0;
        for (int i = 0; i < DW; i++) begin
            logic b;
            int   h;
            b = (k == 0) ? w[i] : w[DW-1-i];
            h = b ? H1 : H0;
            for (int j = 0; j < 2 * h; j++) begin
                m_wave[k][m_len[k]] = (j < h);
                m_len[k]++;
            end
        end
        m_pos[k] = 0;
    endtask

    task automatic model_step(input int k);
        bit acc_ok;
        int t;
        if (reset) begin
            m_run[k] = 0; m_hv[k] = 0; m_acc[k] = 0; m_pos[k] = 0;
            e_wd[k]  = 1'b0;
        end else begin
            acc_ok  = !m_hv[k] && din_valid;
            e_wd[k] = 1'b0;
            if (!m_run[k]) begin
                if (m_hv[k]) begin
                    load_word(k, m_hold[k]);
                    m_run[k] = 1; m_hv[k] = 0; m_acc[k] = 0;
                end
            end else begin
                t        = m_acc[k] + STP;
                m_acc[k] = t % (1 << ACC_W);
                if (t >= (1 << ACC_W)) begin
                    m_pos[k]++;
                    if (m_pos[k] == m_len[k]) begin
                        e_wd[k] = 1'b1;
                        if (m_hv[k]) begin
                            load_word(k, m_hold[k]);
                            m_hv[k] = 0;
                        end else begin
                            m_run[k] = 0; m_acc[k] = 0;
                        end
                    end
                end
            end
            if (acc_ok) begin
                m_hv[k]   = 1;
                m_hold[k] = din;
            end
        end
        e_busy[k] = m_run[k];
        e_dout[k] = m_run[k] ? m_wave[k][m_pos[k]] : 1'b1;
    endtask

    always @(posedge clk) begin
        if (reset) m_on = 1'b1;
        model_step(0);
        model_step(1);
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (m_on) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("dout%0d", k), dout[k], e_dout[k]);
                check($sformatf("busy%0d", k), busy[k], e_busy[k]);
                check($sformatf("word_done%0d", k), wd[k], e_wd[k]);
                check($sformatf("din_ready%0d", k), rdy[k], !reset && !m_hv[k]);
            end
        end
    end

    // ---------------- activity counters for literal expectations -------------
    int   busy_cnt = 0;
    int   wd_cnt   = 0;
    int   rises    = 0;
    logic prev_busy = 1'b0;

    always @(negedge clk) begin
        if (busy[0] === 1'b1) busy_cnt++;
        if (wd[0] === 1'b1) wd_cnt++;
        if (busy[0] === 1'b1 && prev_busy !== 1'b1) rises++;
        prev_busy = busy[0];
    end

    task automatic clr();
        busy_cnt = 0; wd_cnt = 0; rises = 0;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Offer a word and hold it until the handshake completes
    task automatic send(input logic [7:0] w);
        bit ok;
        ok = 0;
        din = w; din_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rdy[0] === 1'b1) begin ok = 1; break; end
        end
        if (!ok) check("send_timeout", 0, 1);
        @(posedge clk); #1;
        din_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (busy === 2'b00 && rdy === 2'b11) begin ok = 1; break; end
        end
        if (!ok) check("idle_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int len[2];
        bit fin[2];

        // Reset held with a word offered
        reset = 1'b1; din_valid = 1'b1; din = 8'hA5;
        @(posedge clk); #1;
        repeat (3) begin
            @(negedge clk);
            check("rst_ready", rdy[0], 0);
            check("rst_dout", dout[0], 1);
            check("rst_busy", busy[0], 0);
        end
        @(posedge clk); #1;
        reset = 1'b0; din_valid = 1'b0;
        @(negedge clk);
        check("ready_after_rst", rdy[0], 1);
        @(posedge clk); #1;

        // Single word 0x01: 30 ticks = 60 clks
        clr();
        send(8'h01);
        wait_idle();
        check("w01_busy_clks", busy_cnt, 60);
        check("w01_done_pulses", wd_cnt, 1);

        // Back-to-back 0xFF, 0x00: 48 ticks, no gap
        clr();
        send(8'hFF);
        send(8'h00);
        wait_idle();
        check("b2b_busy_clks", busy_cnt, 96);
        check("b2b_done_pulses", wd_cnt, 2);
        check("b2b_busy_rises", rises, 1);

        // Backpressure: third word waits for the first to finish
        clr();
        send(8'($urandom));
        send(8'($urandom));
        send(8'($urandom));
        check("bp_w3_after_w1", wd_cnt, 1);
        wait_idle();
        check("bp_done_pulses", wd_cnt, 3);

        // Reset mid-bit with a word held
        send(8'h55);
        send(8'($urandom));
        cyc(7);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        clr();
        @(negedge clk);
        check("abort_dout", dout[0], 1);
        check("abort_busy", busy[0], 0);
        check("abort_ready", rdy[0], 1);
        @(posedge clk); #1;
        cyc(200);
        check("abort_no_done", wd_cnt, 0);
        check("abort_no_busy", busy_cnt, 0);

        // Word 0x80: MSB-first starts with a short cycle, LSB-first with a long one
        send(8'h80);
        len[0] = 0; len[1] = 0; fin[0] = 0; fin[1] = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (busy[k] === 1'b1 && !fin[k]) begin
                    if (dout[k] === 1'b1) len[k]++;
                    else fin[k] = 1;
                end
            end
        end
        check("w80_lsb_first_high", len[0], 4);
        check("w80_msb_first_high", len[1], 2);
        @(posedge clk); #1;
        wait_idle();

        // Randomised traffic with gaps and occasional aborts
        for (int n = 0; n < 40; n++) begin
            send(8'($urandom));
            if ($urandom_range(0, 2) != 0) cyc($urandom_range(0, 90));
            if ($urandom_range(0, 7) == 0) begin
                reset = 1'b1;
                cyc(1);
                reset = 1'b0;
            end
        end
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cas_fsk_stream.md
Name: cas_fsk_stream

Overview:
- Parametrised cassette FSK bit-stream encoder for the CoCo tape-out path.
- Accepts data words over a valid/ready handshake and buffers one word.
- Serialises each word as square-wave cycles: a '1' bit is a short cycle, a '0' bit is a long cycle.
- Timing comes from a fractional phase accumulator, so bit rates are exact at any system clock. Words are emitted back-to-back with no gap and no phase reset.

Parameters:
- ACC_W, 24: phase accumulator width. The carry out of (acc + STP) is one tick.
- STP, 703: accumulator increment per clk. Must satisfy 0 < STP < 2^ACC_W. Tick rate = f_clk * STP / 2^ACC_W.
- DW, 8: bits per word.
- H1, 1: ticks per half-cycle for a '1' bit (must be >= 1).
- H0, 2: ticks per half-cycle for a '0' bit (must be >= 1).
- IDLE_LVL, 1'b1: dout level when idle. This is also the level of the first half of every bit cycle.
- LSB_FIRST, 1: 1 = bit 0 sent first; 0 = bit DW-1 sent first.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- din, input, DW: word to transmit.
- din_valid, input, 1: din is valid.
- din_ready, output, 1: hold register can accept a word. Equals ~reset & ~hold_valid (combinational).
- dout, output, 1: FSK square-wave output.
- busy, output, 1: high while in RUN state.
- word_done, output, 1: one-clk pulse on the edge that completes a word's last bit.

Behaviour:
- Reset (sampled on a clk edge):
  - state=IDLE, acc=0, cycle counter cnt=0, bit index=0, hold_valid=0.
  - dout=IDLE_LVL, busy=0, word_done=0.
  - din_ready is low while reset is high.
- Reset mid-word aborts immediately. The next cycle shows dout=IDLE_LVL. Any held word is discarded.
- Handshake:
  - A word transfers on any edge where din_valid & din_ready. hold<=din and hold_valid<=1.
  - The hold register is a single entry. din_ready stays low until the word moves to the shifter.
- Tick: tick = carry of (acc + STP), computed combinationally from registered acc. In RUN, acc <= acc + STP (mod 2^ACC_W) every clk. In IDLE, acc is held at 0.
- State IDLE:
  - dout=IDLE_LVL.
  - If hold_valid: load the shifter from hold, hold_valid<=0, cnt<=0, bit index<=0, state<=RUN.
  - Latency: a word accepted at edge E enters RUN at edge E+1. The first tick is no earlier than E+2.
- State RUN:
  - Current bit b = shifter[0] (LSB_FIRST) or shifter[DW-1].
  - Half length H = b ? H1 : H0. cnt width = clog2(2*max(H0,H1)).
  - dout = (cnt < H) ? IDLE_LVL : ~IDLE_LVL, registered from cnt and b.
  - On each tick, cnt <= cnt + 1.
  - On a tick where cnt == 2H-1: cnt<=0, shift the shifter toward the sent end, bit index += 1.
  - End of word (bit index == DW-1 with the same end condition):
    - word_done=1 for one clk.
    - If hold_valid: reload the shifter from hold in the same edge and clear hold_valid. Stay in RUN. acc is not cleared, so phase is continuous and the waveform is gapless.
    - Else: state<=IDLE, acc<=0, dout returns to IDLE_LVL.
- Simultaneous events:
  - Reload from hold and a new din transfer cannot coincide, because din_ready was low.
  - On the cycle after the reload, din_ready rises.
- Word duration in ticks = sum over bits of 2*H(b).
- Outputs other than din_ready are registered.

Test Plan:
Bench uses ACC_W=4, STP=8 (tick every 2nd clk), DW=8, H1=1, H0=2, IDLE_LVL=1.
- Reset: hold reset for 3 clks with din_valid=1 -> din_ready=0 throughout; dout=1, busy=0; din_ready=1 on the first clk after release.
- Single word 0x01:
  - Bit 0 = 1 tick high + 1 tick low.
  - Bits 1-7 = 2 ticks high + 2 ticks low each.
  - Total 30 ticks = 60 clks of busy.
  - Exactly one word_done pulse, then dout=1 and busy=0.
- Back-to-back 0xFF then 0x00 (second word presented while the first runs):
  - No idle gap; busy stays continuously high.
  - 16 + 32 = 48 ticks total; word_done pulses twice.
  - din_ready rises the clk after the first word reloads into the shifter.
- Backpressure with 3 words offered continuously:
  - Word 1 goes to the shifter and word 2 to hold.
  - din_ready stays low until word 1 completes; word 3 is accepted only then.
  - All 3 words are emitted in order.
- Reset asserted mid-bit during word 0x55 with a word held -> next clk dout=1, busy=0, din_ready=1; no word_done; the held word is never emitted.
- LSB_FIRST=0, word 0x80 -> the first bit emitted is the short 2-tick cycle, followed by 7 long 4-tick cycles.
